// File: rtl/p4_int_pkg.sv
// Shared definitions for the interrupt requester and the instruction-injection controller.
package p4_int_pkg;

  localparam int unsigned NUM_IRQ_DEFAULT = 16;
  localparam int unsigned VEC_W           = 4;

  // Upper opcode bits of the injected INT instruction; the vector fills the low bits.
  localparam logic [11:0] INT_OPCODE_PREFIX = 12'b010001110000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    HOLD    = 2'd2
  } int_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line synchroniser and rising-edge detector for one asynchronous interrupt line.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic irq_async,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] vld_q, vld_d;
  logic                   hist_q, hist_d;
  logic                   hist_vld_q, hist_vld_d;

  // vld tracks which stages hold real post-reset samples, so a line already high
  // when reset releases is not mistaken for a fresh edge.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], irq_async};
    vld_d      = {vld_q[SYNC_STAGES-2:0], 1'b1};
    hist_d     = sync_q[SYNC_STAGES-1];
    hist_vld_d = vld_q[SYNC_STAGES-1];
    rise_c     = sync_q[SYNC_STAGES-1] & ~hist_q & hist_vld_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q     <= '0;
      vld_q      <= '0;
      hist_q     <= 1'b0;
      hist_vld_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      vld_q      <= vld_d;
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
    end
  end

endmodule

// File: rtl/interrupt_requester.sv
// Latches synchronised interrupt edges, arbitrates by fixed priority and holds one
// committed request towards the injection controller until acknowledged.
module interrupt_requester
  import p4_int_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = NUM_IRQ_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLDOFF     = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               global_en,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               int_ack,
  output logic               int_en,
  output logic [VEC_W-1:0]   int_val,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);

  localparam int unsigned HOLD_W = 4;

  int_state_e         state_q, state_d;
  logic               int_en_q, int_en_d;
  logic [VEC_W-1:0]   int_val_q, int_val_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  logic [NUM_IRQ-1:0] rise_c;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [VEC_W-1:0]   winner;
  logic               found;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
    irq_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
      .clock    (clock),
      .reset    (reset),
      .irq_async(irq[g]),
      .rise_c   (rise_c[g])
    );
  end

  // Lowest-index eligible line wins.
  always_comb begin
    eligible = pending_q & mask_q;
    winner   = '0;
    found    = 1'b0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (eligible[i] && !found) begin
        winner = VEC_W'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    int_en_d   = int_en_q;
    int_val_d  = int_val_q;
    hold_cnt_d = hold_cnt_q;
    ack_clr    = '0;
    mask_d     = mask_we ? mask_wdata : mask_q;

    unique case (state_q)
      IDLE: begin
        if (global_en && found) begin
          int_en_d  = 1'b1;
          int_val_d = winner;
          state_d   = REQUEST;
        end
      end
      REQUEST: begin
        if (int_ack) begin
          ack_clr[int_val_q] = 1'b1;
          int_en_d           = 1'b0;
          hold_cnt_d         = HOLD_W'(HOLDOFF);
          state_d            = HOLD;
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        if (hold_cnt_q <= HOLD_W'(1)) begin
          hold_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        int_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    // A new edge on the acknowledged line outranks the clear, so the event survives.
    pending_d = (pending_q & ~ack_clr) | rise_c;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      int_en_q   <= 1'b0;
      int_val_q  <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      int_en_q   <= int_en_d;
      int_val_q  <= int_val_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign int_en  = int_en_q;
  assign int_val = int_val_q;
  assign pending = pending_q;
  assign mask    = mask_q;

endmodule

// File: tb/tb_interrupt_requester.sv
// Scoreboard bench for interrupt_requester: directed scenarios plus randomized traffic.
module tb_interrupt_requester;

  localparam int unsigned N       = 16;
  localparam int unsigned SYNC    = 2;
  localparam int unsigned HOLDOFF = 2;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] irq = '0;
  logic         global_en = 1'b0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_wdata = '0;
  logic         int_ack = 1'b0;
  logic         int_en;
  logic [3:0]   int_val;
  logic [N-1:0] pending;
  logic [N-1:0] mask;

  always #5 clock = ~clock;

  interrupt_requester #(
    .NUM_IRQ    (N),
    .SYNC_STAGES(SYNC),
    .HOLDOFF    (HOLDOFF)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .irq       (irq),
    .global_en (global_en),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .int_ack   (int_ack),
    .int_en    (int_en),
    .int_val   (int_val),
    .pending   (pending),
    .mask      (mask)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: events scheduled by absolute cycle number.
  logic [N-1:0] m_pending = '0;
  logic [N-1:0] m_mask = '0;
  logic         m_int_en = 1'b0;
  logic [3:0]   m_int_val = '0;
  int           cyc = 0;
  int           next_ok = 0;
  int           n_smp = 0;
  logic [N-1:0] prev_smp = '0;
  logic [N-1:0] set_at [int];
  logic [3:0]   exp_q [$];
  logic [N-1:0] m_elig, m_clr, m_set;

  function automatic logic [3:0] lowest(input logic [N-1:0] v);
    logic [3:0] r = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      m_pending = '0;
      m_mask    = '0;
      m_int_en  = 1'b0;
      m_int_val = '0;
      next_ok   = 0;
      n_smp     = 0;
      prev_smp  = '0;
      set_at.delete();
    end else begin
      m_elig = m_pending & m_mask;
      m_clr  = '0;
      m_set  = set_at.exists(cyc) ? set_at[cyc] : '0;
      if (m_int_en) begin
        if (int_ack) begin
          m_clr[m_int_val] = 1'b1;
          m_int_en         = 1'b0;
          next_ok          = cyc + int'(HOLDOFF) + 1;
        end
      end else if (cyc >= next_ok && global_en && m_elig != '0) begin
        m_int_val = lowest(m_elig);
        m_int_en  = 1'b1;
        exp_q.push_back(m_int_val);
      end
      m_pending = (m_pending & ~m_clr) | m_set;
      if (mask_we) m_mask = mask_wdata;
      // A 0->1 between two post-reset samples becomes pending SYNC edges later.
      if (n_smp >= 1) set_at[cyc + int'(SYNC)] = irq & ~prev_smp;
      prev_smp = irq;
      n_smp++;
    end
  end

  // Monitor: per-cycle state compare plus request scoreboard.
  logic       prev_en = 1'b0;
  logic [3:0] cur_exp;
  always @(negedge clock) begin
    check("pending", 32'(pending), 32'(m_pending));
    check("mask", 32'(mask), 32'(m_mask));
    check("int_en", 32'(int_en), 32'(m_int_en));
    check("int_val", 32'(int_val), 32'(m_int_val));
    if (int_en && !prev_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_request actual=vec %0d expected=no request at %0t", int_val, $time);
      end else begin
        cur_exp = exp_q.pop_front();
        check("req_vec", 32'(int_val), 32'(cur_exp));
      end
    end
    prev_en = int_en;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_req(input string name, input int max);
    int n = 0;
    while (!int_en && n < max) begin
      tick(1);
      n++;
    end
    if (!int_en) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=int_en 0 expected=int_en 1 at %0t", name, $time);
    end
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
  endtask

  task automatic write_mask(input logic [N-1:0] v);
    mask_we    = 1'b1;
    mask_wdata = v;
    tick(1);
    mask_we = 1'b0;
  endtask

  task automatic pulse(input logic [N-1:0] v);
    irq = v;
    tick(1);
    irq = '0;
  endtask

  initial begin
    // Reset held with all lines high; nothing may appear after release.
    reset = 1'b0;
    irq   = '1;
    tick(3);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_mask", 32'(mask), 32'h0);
    check("rst_int_en", 32'(int_en), 32'h0);
    check("rst_int_val", 32'(int_val), 32'h0);
    reset = 1'b1;
    tick(6);
    check("rst_no_false_edge", 32'(pending), 32'h0);
    irq = '0;
    tick(4);

    // Single request on line 5.
    global_en = 1'b1;
    write_mask('1);
    pulse(16'h0020);
    tick(2);
    check("single_pending", 32'(pending), 32'h0020);
    check("single_not_yet", 32'(int_en), 32'h0);
    tick(1);
    check("single_en", 32'(int_en), 32'h1);
    check("single_val", 32'(int_val), 32'h5);
    ack();
    check("single_cleared", 32'(pending), 32'h0);
    check("single_en_low", 32'(int_en), 32'h0);
    tick(HOLDOFF);
    check("single_hold", 32'(int_en), 32'h0);

    // Priority between lines 9 and 3.
    pulse(16'h0208);
    wait_req("prio_first", 20);
    check("prio_first", 32'(int_val), 32'h3);
    ack();
    tick(1);
    check("prio_holdoff", 32'(int_en), 32'h0);
    wait_req("prio_second", 20);
    check("prio_second", 32'(int_val), 32'h9);
    ack();
    tick(4);

    // Mask and global enable gating.
    write_mask('0);
    pulse(16'h0004);
    tick(5);
    check("masked_pending", 32'(pending), 32'h0004);
    check("masked_no_req", 32'(int_en), 32'h0);
    global_en = 1'b0;
    write_mask(16'h0004);
    tick(4);
    check("gen_off_no_req", 32'(int_en), 32'h0);
    global_en = 1'b1;
    wait_req("gen_on", 10);
    check("gen_on_val", 32'(int_val), 32'h2);
    ack();
    tick(4);

    // Committed request survives enable drop and a higher-priority arrival.
    write_mask('1);
    pulse(16'h0080);
    wait_req("commit", 20);
    check("commit_val", 32'(int_val), 32'h7);
    global_en = 1'b0;
    pulse(16'h0002);
    tick(6);
    check("commit_held_en", 32'(int_en), 32'h1);
    check("commit_held_val", 32'(int_val), 32'h7);
    ack();
    tick(4);
    check("commit_gen_off", 32'(int_en), 32'h0);
    global_en = 1'b1;
    wait_req("commit_next", 10);
    check("commit_next_val", 32'(int_val), 32'h1);
    ack();
    tick(4);

    // New edge on line 4 lands in the same cycle as its ack.
    pulse(16'h0010);
    wait_req("collide", 20);
    check("collide_val", 32'(int_val), 32'h4);
    pulse(16'h0010);
    tick(1);
    ack();
    check("collide_pend", 32'(pending & 16'h0010), 32'h0010);
    wait_req("collide_again", 20);
    check("collide_again_val", 32'(int_val), 32'h4);
    ack();
    tick(4);

    // Randomized traffic including stray acks and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      irq       = irq ^ N'($urandom & $urandom & $urandom & $urandom);
      global_en = ($urandom_range(7) != 0);
      mask_we   = ($urandom_range(15) == 0);
      mask_wdata = N'($urandom);
      int_ack   = int_en ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
      reset     = ($urandom_range(399) != 0);
      tick(1);
    end
    reset   = 1'b1;
    int_ack = 1'b0;
    mask_we = 1'b0;
    irq     = '0;
    tick(10);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
